// File: rtl/eight_dot_product_accumulator_pkg.sv
// Shared constants and lane helpers for the 8-lane dot-product engine.
package eight_dot_product_accumulator_pkg;

  localparam int unsigned ELEMENT_WIDTH = 32;
  localparam int unsigned NO_OF_UNITS   = 8;
  localparam int unsigned BUS_WIDTH     = ELEMENT_WIDTH * NO_OF_UNITS;

  typedef logic [ELEMENT_WIDTH-1:0] elem_t;
  typedef logic [BUS_WIDTH-1:0]     row_t;

  // Extract element idx from a packed row; element i sits at bits [32i+31:32i].
  function automatic elem_t lane_of(input row_t bus, input int unsigned idx);
    return bus[idx*ELEMENT_WIDTH +: ELEMENT_WIDTH];
  endfunction

endpackage

// File: rtl/eight_dot_product_accumulator_adder_tree.sv
// Combinational three-level reduction of eight 32-bit values, wrapping mod 2^32.
module adder_tree_8
  import eight_dot_product_accumulator_pkg::*;
(
  input  logic [BUS_WIDTH-1:0]     operands,
  output logic [ELEMENT_WIDTH-1:0] sum
);

  elem_t level1 [4];
  elem_t level2 [2];

  // Pairwise sums: 8 -> 4 -> 2 -> 1.
  always_comb begin
    for (int unsigned j = 0; j < 4; j++) begin
      level1[j] = lane_of(operands, 2*j) + lane_of(operands, 2*j + 1);
    end
    for (int unsigned k = 0; k < 2; k++) begin
      level2[k] = level1[2*k] + level1[2*k + 1];
    end
    sum = level2[0] + level2[1];
  end

endmodule

// File: rtl/eight_dot_product_accumulator.sv
// Streaming 8-lane dot product: multiply (S1), reduce (S2), accumulate (S3).
module eight_dot_product_accumulator #(
  parameter int unsigned ELEMENT_WIDTH = eight_dot_product_accumulator_pkg::ELEMENT_WIDTH,
  parameter int unsigned NO_OF_UNITS   = eight_dot_product_accumulator_pkg::NO_OF_UNITS
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [31:0]                          total,
  input  logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0] first_row_input,
  input  logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0] second_row_input,
  input  logic                                 outsider_read_now,
  output logic [ELEMENT_WIDTH-1:0]             result,
  output logic                                 finish
);

  logic [31:0]                          target_beats;
  logic [31:0]                          accepted_cnt;
  logic [31:0]                          done_cnt;
  logic                                 accept;

  logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0] prod_bus;
  logic                                 s1_valid;
  logic [ELEMENT_WIDTH-1:0]             tree_sum;
  logic [ELEMENT_WIDTH-1:0]             sum_reg;
  logic                                 s2_valid;
  logic [ELEMENT_WIDTH-1:0]             acc;

  // Beats per operation and the accept qualifier.
  always_comb begin
    target_beats = total >> 3;
    accept       = outsider_read_now && (accepted_cnt < target_beats);
  end

  // S1: count accepted beats and register the lane products.
  // Truncated two's-complement products equal the low half of the unsigned product.
  always_ff @(posedge clk) begin
    if (reset) begin
      accepted_cnt <= '0;
      prod_bus     <= '0;
      s1_valid     <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        accepted_cnt <= accepted_cnt + 32'd1;
        for (int unsigned i = 0; i < NO_OF_UNITS; i++) begin
          prod_bus[i*ELEMENT_WIDTH +: ELEMENT_WIDTH] <=
            eight_dot_product_accumulator_pkg::lane_of(first_row_input, i) *
            eight_dot_product_accumulator_pkg::lane_of(second_row_input, i);
        end
      end
    end
  end

  adder_tree_8 u_adder_tree (
    .operands (prod_bus),
    .sum      (tree_sum)
  );

  // S2: register the reduced sum of the S1 products.
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_reg  <= '0;
      s2_valid <= 1'b0;
    end else begin
      sum_reg  <= tree_sum;
      s2_valid <= s1_valid;
    end
  end

  // S3: accumulate and raise finish together with the last beat's contribution.
  // N=0 finishes on the first edge out of reset with acc still zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= '0;
      done_cnt <= '0;
      finish   <= 1'b0;
    end else begin
      if (s2_valid) begin
        acc      <= acc + sum_reg;
        done_cnt <= done_cnt + 32'd1;
        if (done_cnt + 32'd1 == target_beats) begin
          finish <= 1'b1;
        end
      end
      if (target_beats == '0) begin
        finish <= 1'b1;
      end
    end
  end

  assign result = acc;

endmodule

// File: tb/tb_eight_dot_product_accumulator.sv
// Directed bench for eight_dot_product_accumulator.
module tb_eight_dot_product_accumulator;

  logic         clk;
  logic         reset;
  logic [31:0]  total;
  logic [255:0] first_row_input;
  logic [255:0] second_row_input;
  logic         outsider_read_now;
  logic [31:0]  result;
  logic         finish;

  int checks;
  int errors;

  eight_dot_product_accumulator #(
    .ELEMENT_WIDTH (32),
    .NO_OF_UNITS   (8)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .total             (total),
    .first_row_input   (first_row_input),
    .second_row_input  (second_row_input),
    .outsider_read_now (outsider_read_now),
    .result            (result),
    .finish            (finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] fill(input logic [31:0] v);
    logic [255:0] b;
    for (int i = 0; i < 8; i++) b[i*32 +: 32] = v;
    return b;
  endfunction

  // Inputs change and outputs are sampled on the falling edge.
  task automatic do_reset(input logic [31:0] tot);
    @(negedge clk);
    reset = 1'b1;
    total = tot;
    outsider_read_now = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic beat(input logic [255:0] a, input logic [255:0] b);
    @(negedge clk);
    first_row_input   = a;
    second_row_input  = b;
    outsider_read_now = 1'b1;
    @(negedge clk);
    outsider_read_now = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(32'd8);
    checks++;
    if (result !== 32'd0) begin errors++; $display("FAIL reset_result got=%h exp=%h", result, 32'd0); end
    checks++;
    if (finish !== 1'b0) begin errors++; $display("FAIL reset_finish got=%b exp=0", finish); end
  endtask

  task automatic test_total_zero();
    do_reset(32'd0);
    checks++;
    if (finish !== 1'b0) begin errors++; $display("FAIL zero_finish_before got=%b exp=0", finish); end
    @(negedge clk);
    checks++;
    if (finish !== 1'b1) begin errors++; $display("FAIL zero_finish got=%b exp=1", finish); end
    checks++;
    if (result !== 32'd0) begin errors++; $display("FAIL zero_result got=%h exp=%h", result, 32'd0); end
  endtask

  task automatic test_single_beat();
    logic [255:0] a;
    do_reset(32'd8);
    for (int i = 0; i < 8; i++) a[i*32 +: 32] = i + 1;
    beat(a, fill(32'd1));
    checks++;
    if (finish !== 1'b0 || result !== 32'd0) begin
      errors++; $display("FAIL single_t0 got=%b/%h exp=0/0", finish, result);
    end
    @(negedge clk);
    checks++;
    if (finish !== 1'b0 || result !== 32'd0) begin
      errors++; $display("FAIL single_t1 got=%b/%h exp=0/0", finish, result);
    end
    @(negedge clk);
    checks++;
    if (finish !== 1'b1) begin errors++; $display("FAIL single_finish got=%b exp=1", finish); end
    checks++;
    if (result !== 32'd36) begin errors++; $display("FAIL single_result got=%h exp=%h", result, 32'd36); end
  endtask

  task automatic test_gaps();
    do_reset(32'd24);
    beat(fill(32'd2), fill(32'd3));
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (result !== 32'd48 || finish !== 1'b0) begin
      errors++; $display("FAIL gaps_beat1 got=%b/%h exp=0/%h", finish, result, 32'd48);
    end
    beat(fill(32'hFFFF_FFFF), fill(32'd4));
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (result !== 32'd16 || finish !== 1'b0) begin
      errors++; $display("FAIL gaps_beat2 got=%b/%h exp=0/%h", finish, result, 32'd16);
    end
    beat(fill(32'd5), fill(32'd5));
    checks++;
    if (finish !== 1'b0) begin errors++; $display("FAIL gaps_early_t0 got=%b exp=0", finish); end
    @(negedge clk);
    checks++;
    if (finish !== 1'b0) begin errors++; $display("FAIL gaps_early_t1 got=%b exp=0", finish); end
    @(negedge clk);
    checks++;
    if (finish !== 1'b1) begin errors++; $display("FAIL gaps_finish got=%b exp=1", finish); end
    checks++;
    if (result !== 32'd216) begin errors++; $display("FAIL gaps_result got=%h exp=%h", result, 32'd216); end
  endtask

  task automatic test_overrun();
    do_reset(32'd16);
    @(negedge clk);
    first_row_input   = fill(32'd1);
    second_row_input  = fill(32'd1);
    outsider_read_now = 1'b1;
    repeat (5) @(negedge clk);
    outsider_read_now = 1'b0;
    checks++;
    if (finish !== 1'b1 || result !== 32'd16) begin
      errors++; $display("FAIL overrun_result got=%b/%h exp=1/%h", finish, result, 32'd16);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (finish !== 1'b1 || result !== 32'd16) begin
        errors++; $display("FAIL overrun_hold[%0d] got=%b/%h exp=1/%h", k, finish, result, 32'd16);
      end
    end
  endtask

  task automatic test_wrap_negative();
    logic [255:0] a;
    logic [255:0] b;
    do_reset(32'd8);
    a = '0;
    b = '0;
    a[31:0] = 32'h7FFF_FFFF;
    b[31:0] = 32'd2;
    beat(a, b);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (finish !== 1'b1 || result !== 32'hFFFF_FFFE) begin
      errors++; $display("FAIL wrap_result got=%b/%h exp=1/%h", finish, result, 32'hFFFF_FFFE);
    end
    do_reset(32'd8);
    beat(fill(32'hFFFF_FFFD), fill(32'd7));
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (finish !== 1'b1 || result !== 32'hFFFF_FF58) begin
      errors++; $display("FAIL negative_result got=%b/%h exp=1/%h", finish, result, 32'hFFFF_FF58);
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset(32'd32);
    @(negedge clk);
    first_row_input   = fill(32'd5);
    second_row_input  = fill(32'd5);
    outsider_read_now = 1'b1;
    @(negedge clk);
    @(negedge clk);
    outsider_read_now = 1'b0;
    @(negedge clk);
    checks++;
    if (result !== 32'd200 || finish !== 1'b0) begin
      errors++; $display("FAIL midrun_partial got=%b/%h exp=0/%h", finish, result, 32'd200);
    end
    reset = 1'b1;
    total = 32'd8;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (result !== 32'd0 || finish !== 1'b0) begin
      errors++; $display("FAIL midrun_cleared got=%b/%h exp=0/0", finish, result);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (result !== 32'd0 || finish !== 1'b0) begin
      errors++; $display("FAIL midrun_no_residue got=%b/%h exp=0/0", finish, result);
    end
    beat(fill(32'd1), fill(32'd1));
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (finish !== 1'b1 || result !== 32'd8) begin
      errors++; $display("FAIL midrun_fresh got=%b/%h exp=1/%h", finish, result, 32'd8);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    total = 32'd8;
    first_row_input   = '0;
    second_row_input  = '0;
    outsider_read_now = 1'b0;
    test_reset();
    test_total_zero();
    test_single_beat();
    test_gaps();
    test_overrun();
    test_wrap_negative();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
